// File: rtl/home_event_scheduler.sv
// Round-robin service scheduler: polls N_SENS sensor slots plus one hysteresis-filtered
// temperature slot, grants one actuator at a time for DWELL cycles and reports the served slot.
//
// state | meaning
// IDLE  | no request pending, all grants and display cleared
// SCAN  | examining req[ptr] once per cycle, advancing ptr on a miss
// SERVE | one grant held high while the dwell down-counter runs to zero
module home_event_scheduler #(
    parameter int N_SENS = 4,
    parameter int TW     = 8,
    parameter int T_HIGH = 70,
    parameter int T_LOW  = 50,
    parameter int HYST   = 2,
    parameter int DWELL  = 1
) (
    input  logic                        clk,
    input  logic                        Rst,
    input  logic [N_SENS-1:0]           sens,
    input  logic [TW-1:0]               temp,
    output logic [N_SENS-1:0]           act,
    output logic                        cooler,
    output logic                        heater,
    output logic [$clog2(N_SENS+2)-1:0] display,
    output logic                        busy
);

    localparam int DW = $clog2(N_SENS + 2);
    localparam int PW = (N_SENS > 0) ? $clog2(N_SENS + 1) : 1;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [PW-1:0] PTR_MAX   = PW'(N_SENS);
    localparam logic [CW-1:0] CNT_LOAD  = CW'(DWELL - 1);
    localparam logic [TW-1:0] COOL_SET  = TW'(T_HIGH);
    localparam logic [TW-1:0] COOL_CLR  = TW'(T_HIGH - HYST);
    localparam logic [TW-1:0] HEAT_SET  = TW'(T_LOW);
    localparam logic [TW-1:0] HEAT_CLR  = TW'(T_LOW + HYST);

    if (T_LOW + HYST > T_HIGH - HYST) begin : g_bad_hyst
        $error("home_event_scheduler: hysteresis bands overlap (T_LOW+HYST > T_HIGH-HYST)");
    end
    if (N_SENS < 1) begin : g_bad_nsens
        $error("home_event_scheduler: N_SENS must be at least 1");
    end
    if (DWELL < 1) begin : g_bad_dwell
        $error("home_event_scheduler: DWELL must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        SERVE = 2'd2
    } state_t;

    state_t              state, state_d;
    logic [PW-1:0]       ptr, ptr_d, ptr_inc;
    logic [CW-1:0]       count, count_d;
    logic [N_SENS-1:0]   act_d;
    logic                cooler_d, heater_d, busy_d;
    logic [DW-1:0]       display_d;
    logic                cool_req, heat_req;
    logic [N_SENS:0]     req;
    logic                any_req;

    // Hysteresis flags track temperature every cycle, whatever the scheduler is doing.
    always_ff @(posedge clk) begin
        if (Rst) begin
            cool_req <= 1'b0;
            heat_req <= 1'b0;
        end else begin
            if (temp > COOL_SET) begin
                cool_req <= 1'b1;
            end else if (temp <= COOL_CLR) begin
                cool_req <= 1'b0;
            end
            if (temp < HEAT_SET) begin
                heat_req <= 1'b1;
            end else if (temp >= HEAT_CLR) begin
                heat_req <= 1'b0;
            end
        end
    end

    assign req     = {cool_req | heat_req, sens};
    assign any_req = |req;
    assign ptr_inc = (ptr == PTR_MAX) ? '0 : ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (Rst) begin
            state   <= IDLE;
            ptr     <= '0;
            count   <= '0;
            act     <= '0;
            cooler  <= 1'b0;
            heater  <= 1'b0;
            display <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_d;
            ptr     <= ptr_d;
            count   <= count_d;
            act     <= act_d;
            cooler  <= cooler_d;
            heater  <= heater_d;
            display <= display_d;
            busy    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        count_d   = count;
        act_d     = act;
        cooler_d  = cooler;
        heater_d  = heater;
        display_d = display;
        busy_d    = busy;

        case (state)
            IDLE: begin
                act_d     = '0;
                cooler_d  = 1'b0;
                heater_d  = 1'b0;
                display_d = '0;
                busy_d    = 1'b0;
                if (any_req) begin
                    state_d = SCAN;
                end
            end

            SCAN: begin
                act_d    = '0;
                cooler_d = 1'b0;
                heater_d = 1'b0;
                busy_d   = 1'b0;
                if (req[ptr]) begin
                    state_d   = SERVE;
                    busy_d    = 1'b1;
                    count_d   = CNT_LOAD;
                    display_d = DW'(ptr) + DW'(1);
                    // Temperature mode is latched here and held for the whole dwell.
                    if (ptr == PTR_MAX) begin
                        cooler_d = cool_req;
                        heater_d = ~cool_req;
                    end else begin
                        act_d = N_SENS'(1) << ptr;
                    end
                end else if (!any_req) begin
                    state_d   = IDLE;
                    display_d = '0;
                end else begin
                    ptr_d = ptr_inc;
                end
            end

            SERVE: begin
                if (count == '0) begin
                    state_d  = SCAN;
                    act_d    = '0;
                    cooler_d = 1'b0;
                    heater_d = 1'b0;
                    busy_d   = 1'b0;
                    ptr_d    = ptr_inc;
                end else begin
                    count_d = count - CW'(1);
                end
            end

            default: begin
                state_d   = IDLE;
                act_d     = '0;
                cooler_d  = 1'b0;
                heater_d  = 1'b0;
                display_d = '0;
                busy_d    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_home_event_scheduler.sv
// Directed bench for home_event_scheduler (N_SENS=4, DWELL=2) with a per-cycle reference model
// and hand-timed literal checkpoints.
module tb_home_event_scheduler;

    localparam int NS = 4;
    localparam int DWL = 2;

    logic          clk = 1'b0;
    logic          Rst = 1'b1;
    logic [NS-1:0] sens = '0;
    logic [7:0]    temp = 8'd60;
    logic [NS-1:0] act;
    logic          cooler, heater, busy;
    logic [2:0]    display;

    int err_cnt = 0;
    int chk_cnt = 0;
    bit chk_en  = 1'b0;

    home_event_scheduler #(
        .N_SENS(NS), .TW(8), .T_HIGH(70), .T_LOW(50), .HYST(2), .DWELL(DWL)
    ) dut (
        .clk(clk), .Rst(Rst), .sens(sens), .temp(temp),
        .act(act), .cooler(cooler), .heater(heater), .display(display), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: slot pointer, remaining grant cycles and served slot as plain integers.
    int         m_ptr = 0;
    int         m_left = 0;
    int         m_grant = -1;
    int         m_disp = 0;
    bit         m_scan = 1'b0;
    bit         m_mode_cool = 1'b0;
    bit         m_cool = 1'b0;
    bit         m_heat = 1'b0;
    logic [4:0] m_req;

    always @(posedge clk) begin
        if (Rst) begin
            m_ptr = 0; m_left = 0; m_grant = -1; m_disp = 0;
            m_scan = 1'b0; m_mode_cool = 1'b0; m_cool = 1'b0; m_heat = 1'b0;
        end else begin
            m_req = {m_cool | m_heat, sens};
            if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_grant = -1;
                    m_ptr = (m_ptr + 1) % (NS + 1);
                end
            end else if (!m_scan) begin
                if (m_req != 0) m_scan = 1'b1;
            end else if (m_req[m_ptr]) begin
                m_grant = m_ptr;
                m_left = DWL;
                m_mode_cool = m_cool;
                m_disp = m_ptr + 1;
            end else if (m_req == 0) begin
                m_scan = 1'b0;
                m_disp = 0;
            end else begin
                m_ptr = (m_ptr + 1) % (NS + 1);
            end
            if (temp > 8'd70) m_cool = 1'b1;
            else if (temp <= 8'd68) m_cool = 1'b0;
            if (temp < 8'd50) m_heat = 1'b1;
            else if (temp >= 8'd52) m_heat = 1'b0;
        end
    end

    logic [NS-1:0] e_act;
    logic          e_cool, e_heat, e_busy;
    logic [2:0]    e_disp;

    always @(negedge clk) begin
        if (chk_en) begin
            e_act  = (m_grant >= 0 && m_grant < NS) ? NS'(1) << m_grant : '0;
            e_cool = (m_grant == NS) && m_mode_cool;
            e_heat = (m_grant == NS) && !m_mode_cool;
            e_busy = (m_grant >= 0);
            e_disp = 3'(m_disp);
            chk_cnt++;
            if ({act, cooler, heater, display, busy} !== {e_act, e_cool, e_heat, e_disp, e_busy}) begin
                err_cnt++;
                $display("FAIL model t=%0t: got act=%b cool=%b heat=%b disp=%0d busy=%b, want act=%b cool=%b heat=%b disp=%0d busy=%b",
                         $time, act, cooler, heater, display, busy, e_act, e_cool, e_heat, e_disp, e_busy);
            end
            chk_cnt++;
            if ($countones({act, cooler, heater}) > 1) begin
                err_cnt++;
                $display("FAIL onegrant t=%0t: got grants=%b, want at most one", $time, {act, cooler, heater});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic lit(input string nm, input logic [NS-1:0] ea, input logic ec, input logic eh,
                       input logic [2:0] ed, input logic eb);
        chk_cnt++;
        if ({act, cooler, heater, display, busy} !== {ea, ec, eh, ed, eb}) begin
            err_cnt++;
            $display("FAIL %s: got act=%b cool=%b heat=%b disp=%0d busy=%b, want act=%b cool=%b heat=%b disp=%0d busy=%b",
                     nm, act, cooler, heater, display, busy, ea, ec, eh, ed, eb);
        end
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        tick(2);
        Rst = 1'b0;
    endtask

    logic [NS-1:0] v_sens [10] = '{4'b0000, 4'b1000, 4'b0011, 4'b0000, 4'b0110,
                                   4'b1111, 4'b0000, 4'b1001, 4'b0000, 4'b0100};
    logic [7:0]    v_temp [10] = '{8'd75, 8'd69, 8'd67, 8'd45, 8'd51,
                                   8'd53, 8'd60, 8'd71, 8'd0, 8'd255};

    initial begin
        // 1: reset with everything requesting
        Rst = 1'b1; sens = 4'hF; temp = 8'd90;
        tick(1);
        chk_en = 1'b1;
        tick(1);
        lit("reset", 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0);

        // 2: two sensor slots alternate, temp slot idle
        Rst = 1'b0; sens = 4'b0101; temp = 8'd60;
        tick(2);  lit("rr_s0_a", 4'b0001, 1'b0, 1'b0, 3'd1, 1'b1);
        tick(1);  lit("rr_s0_b", 4'b0001, 1'b0, 1'b0, 3'd1, 1'b1);
        tick(1);  lit("rr_gap",  4'b0000, 1'b0, 1'b0, 3'd1, 1'b0);
        tick(2);  lit("rr_s2",   4'b0100, 1'b0, 1'b0, 3'd3, 1'b1);
        tick(5);  lit("rr_wrap", 4'b0001, 1'b0, 1'b0, 3'd1, 1'b1);
        tick(10);

        // 3: cooling with hysteresis
        sens = '0; do_reset();
        temp = 8'd71; tick(1);
        temp = 8'd69; tick(6);
        lit("cool_a", 4'b0000, 1'b1, 1'b0, 3'd5, 1'b1);
        tick(1);  lit("cool_b", 4'b0000, 1'b1, 1'b0, 3'd5, 1'b1);
        temp = 8'd68;
        tick(2);  lit("cool_clr", 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0);
        tick(10); lit("cool_idle", 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0);

        // 4: heating with hysteresis
        do_reset();
        temp = 8'd49; tick(1);
        temp = 8'd51; tick(6);
        lit("heat_a", 4'b0000, 1'b0, 1'b1, 3'd5, 1'b1);
        tick(7);  lit("heat_hold", 4'b0000, 1'b0, 1'b1, 3'd5, 1'b1);
        temp = 8'd52;
        tick(3);  lit("heat_clr", 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0);

        // 5: request dropped mid-serve, then resume from the next pointer
        temp = 8'd60; do_reset();
        sens = 4'b0001;
        tick(2);  lit("drop_a", 4'b0001, 1'b0, 1'b0, 3'd1, 1'b1);
        sens = 4'b0000;
        tick(1);  lit("drop_b", 4'b0001, 1'b0, 1'b0, 3'd1, 1'b1);
        tick(2);  lit("drop_idle", 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0);
        sens = 4'b0100;
        tick(2);  lit("resume_scan", 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0);
        tick(1);  lit("resume_s2", 4'b0100, 1'b0, 1'b0, 3'd3, 1'b1);

        // 6: reset during serve clears pointer and hysteresis flags
        temp = 8'd75;
        tick(1);  lit("pre_rst", 4'b0100, 1'b0, 1'b0, 3'd3, 1'b1);
        Rst = 1'b1; temp = 8'd69; sens = 4'hF;
        tick(1);  lit("mid_rst", 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0);
        Rst = 1'b0; sens = 4'b0000;
        tick(5);  lit("flags_clr", 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0);
        sens = 4'hF;
        tick(2);  lit("ptr_zero", 4'b0001, 1'b0, 1'b0, 3'd1, 1'b1);

        // mixed traffic, model-checked every cycle
        for (int i = 0; i < 10; i++) begin
            sens = v_sens[i];
            temp = v_temp[i];
            tick(9);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
